// File: rtl/wb_dest_pipe_pkg.sv
// rtl/wb_dest_pipe_pkg.sv - slot type, writeback source codes and slot helpers
package wb_dest_pipe_pkg;

    localparam logic [1:0] WB_SRC_ALU = 2'd0;
    localparam logic [1:0] WB_SRC_MEM = 2'd1;
    localparam logic [1:0] WB_SRC_PC4 = 2'd2;

    typedef struct packed {
        logic       valid;
        logic [4:0] wbsel;
        logic       is_load;
        logic       has_link;
    } slot_t;

    localparam slot_t BUBBLE = '0;

    // Flags are dropped for $0 so forwarding can never match it; link wins over load.
    function automatic slot_t make_slot(input logic [4:0] wbsel, input logic is_load,
                                        input logic has_link);
        slot_t s;
        s.valid    = 1'b1;
        s.wbsel    = wbsel;
        s.has_link = has_link && (wbsel != 5'd0);
        s.is_load  = is_load && !has_link && (wbsel != 5'd0);
        return s;
    endfunction

    function automatic logic [1:0] wb_src(input slot_t s);
        if (s.is_load)
            return WB_SRC_MEM;
        else if (s.has_link)
            return WB_SRC_PC4;
        else
            return WB_SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_stage_slot.sv
// rtl/wb_stage_slot.sv - one pipeline slot register with clear and bubble insert
module wb_stage_slot
    import wb_dest_pipe_pkg::*;
(
    input  logic  clk,
    input  logic  clear,
    input  logic  bubble,
    input  slot_t d,
    output slot_t q
);

    always_ff @(posedge clk) begin
        if (clear || bubble)
            q <= BUBBLE;
        else
            q <= d;
    end

endmodule

// File: rtl/wb_dest_pipe.sv
// rtl/wb_dest_pipe.sv - destination/writeback-class pipe from ID to WB with stall/flush counters
module wb_dest_pipe
    import wb_dest_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ID_valid,
    input  logic [4:0]       ID_WBSel,
    input  logic             ID_is_load,
    input  logic             ID_has_link,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       EX_WBSel,
    output logic             EX_is_load,
    output logic             EX_has_link,
    output logic [4:0]       MEM_WBSel,
    output logic             MEM_is_load,
    output logic             MEM_has_link,
    output logic [4:0]       WB_WBSel,
    output logic             WB_RegWrite,
    output logic [1:0]       WB_Src,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    slot_t id_slot, ex_q, mem_q, wb_q;
    logic  ex_bubble;

    assign id_slot   = make_slot(ID_WBSel, ID_is_load, ID_has_link);
    assign ex_bubble = stall || flush || !ID_valid;

    wb_stage_slot u_ex (
        .clk    (clk),
        .clear  (rst),
        .bubble (ex_bubble),
        .d      (id_slot),
        .q      (ex_q)
    );

    wb_stage_slot u_mem (
        .clk    (clk),
        .clear  (rst),
        .bubble (1'b0),
        .d      (ex_q),
        .q      (mem_q)
    );

    wb_stage_slot u_wb (
        .clk    (clk),
        .clear  (rst),
        .bubble (1'b0),
        .d      (mem_q),
        .q      (wb_q)
    );

    assign EX_WBSel     = ex_q.wbsel;
    assign EX_is_load   = ex_q.is_load;
    assign EX_has_link  = ex_q.has_link;
    assign MEM_WBSel    = mem_q.wbsel;
    assign MEM_is_load  = mem_q.is_load;
    assign MEM_has_link = mem_q.has_link;
    assign WB_WBSel     = wb_q.wbsel;
    assign WB_RegWrite  = wb_q.valid && (wb_q.wbsel != 5'd0);
    assign WB_Src       = wb_src(wb_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_dest_pipe.sv
// tb/tb_wb_dest_pipe.sv - scoreboard bench for wb_dest_pipe with directed vectors
module tb_wb_dest_pipe;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             ID_valid;
    logic [4:0]       ID_WBSel;
    logic             ID_is_load;
    logic             ID_has_link;
    logic             stall;
    logic             flush;
    logic [4:0]       EX_WBSel;
    logic             EX_is_load;
    logic             EX_has_link;
    logic [4:0]       MEM_WBSel;
    logic             MEM_is_load;
    logic             MEM_has_link;
    logic [4:0]       WB_WBSel;
    logic             WB_RegWrite;
    logic [1:0]       WB_Src;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    wb_dest_pipe #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ID_valid     (ID_valid),
        .ID_WBSel     (ID_WBSel),
        .ID_is_load   (ID_is_load),
        .ID_has_link  (ID_has_link),
        .stall        (stall),
        .flush        (flush),
        .EX_WBSel     (EX_WBSel),
        .EX_is_load   (EX_is_load),
        .EX_has_link  (EX_has_link),
        .MEM_WBSel    (MEM_WBSel),
        .MEM_is_load  (MEM_is_load),
        .MEM_has_link (MEM_has_link),
        .WB_WBSel     (WB_WBSel),
        .WB_RegWrite  (WB_RegWrite),
        .WB_Src       (WB_Src),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    typedef struct {
        string      tag;
        logic [4:0] exs;
        logic       exl;
        logic       exk;
        logic [4:0] ms;
        logic       ml;
        logic       mk;
        logic [4:0] ws;
        logic       rw;
        logic [1:0] src;
        logic [3:0] sc;
        logic [3:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input string fld, input logic [31:0] act,
                       input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, expv);
        end
    endtask

    // Monitor: the DUT presents a new output set every cycle; compare against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk(e.tag, "EX_WBSel",     32'(EX_WBSel),     32'(e.exs));
            chk(e.tag, "EX_is_load",   32'(EX_is_load),   32'(e.exl));
            chk(e.tag, "EX_has_link",  32'(EX_has_link),  32'(e.exk));
            chk(e.tag, "MEM_WBSel",    32'(MEM_WBSel),    32'(e.ms));
            chk(e.tag, "MEM_is_load",  32'(MEM_is_load),  32'(e.ml));
            chk(e.tag, "MEM_has_link", 32'(MEM_has_link), 32'(e.mk));
            chk(e.tag, "WB_WBSel",     32'(WB_WBSel),     32'(e.ws));
            chk(e.tag, "WB_RegWrite",  32'(WB_RegWrite),  32'(e.rw));
            chk(e.tag, "WB_Src",       32'(WB_Src),       32'(e.src));
            chk(e.tag, "stall_cnt",    32'(stall_cnt),    32'(e.sc));
            chk(e.tag, "flush_cnt",    32'(flush_cnt),    32'(e.fc));
        end
    end

    // Drive one cycle of inputs; the expected outputs after that edge go on the scoreboard.
    task automatic step(input string tag, input logic r, input logic v, input logic [4:0] sel,
                        input logic ld, input logic lk, input logic st, input logic fl,
                        input logic [4:0] exs, input logic exl, input logic exk,
                        input logic [4:0] ms, input logic ml, input logic mk,
                        input logic [4:0] ws, input logic rw, input logic [1:0] src,
                        input logic [3:0] sc, input logic [3:0] fc);
        exp_t e;
        @(negedge clk);
        rst = r; ID_valid = v; ID_WBSel = sel; ID_is_load = ld; ID_has_link = lk;
        stall = st; flush = fl;
        @(posedge clk);
        e.tag = tag; e.exs = exs; e.exl = exl; e.exk = exk; e.ms = ms; e.ml = ml; e.mk = mk;
        e.ws = ws; e.rw = rw; e.src = src; e.sc = sc; e.fc = fc;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; ID_valid = 1'b1; ID_WBSel = 5'd5; ID_is_load = 1'b0; ID_has_link = 1'b0;
        stall = 1'b0; flush = 1'b0;
        //         tag       r v sel ld lk st fl   exs l k   ms l k   ws rw src  sc fc
        step("rst_a",     1,1, 5, 0,0, 0,0,   0,0,0,   0,0,0,   0,0,0,   0,0);
        step("rst_b",     1,1, 5, 0,0, 0,0,   0,0,0,   0,0,0,   0,0,0,   0,0);
        step("alu8_ex",   0,1, 8, 0,0, 0,0,   8,0,0,   0,0,0,   0,0,0,   0,0);
        step("alu8_mem",  0,0, 0, 0,0, 0,0,   0,0,0,   8,0,0,   0,0,0,   0,0);
        step("alu8_wb",   0,0, 0, 0,0, 0,0,   0,0,0,   0,0,0,   8,1,0,   0,0);
        step("lw9_ex",    0,1, 9, 1,0, 0,0,   9,1,0,   0,0,0,   0,0,0,   0,0);
        step("lw9_stall", 0,1,10, 0,0, 1,0,   0,0,0,   9,1,0,   0,0,0,   1,0);
        step("dep_ex",    0,1,10, 0,0, 0,0,  10,0,0,   0,0,0,   9,1,1,   1,0);
        step("dep_mem",   0,0, 0, 0,0, 0,0,   0,0,0,  10,0,0,   0,0,0,   1,0);
        step("stfl_4",    0,1, 4, 0,0, 1,1,   0,0,0,   0,0,0,  10,1,0,   2,1);
        step("stfl_mem",  0,0, 0, 0,0, 0,0,   0,0,0,   0,0,0,   0,0,0,   2,1);
        step("jal_ex",    0,1,31, 0,1, 0,0,  31,0,1,   0,0,0,   0,0,0,   2,1);
        step("zld_ex",    0,1, 0, 1,0, 0,0,   0,0,0,  31,0,1,   0,0,0,   2,1);
        step("both_ex",   0,1, 7, 1,1, 0,0,   7,0,1,   0,0,0,  31,1,2,   2,1);
        step("zld_wb",    0,0, 0, 0,0, 0,0,   0,0,0,   7,0,1,   0,0,0,   2,1);
        step("both_wb",   0,0, 0, 0,0, 0,0,   0,0,0,   0,0,0,   7,1,2,   2,1);
        step("flush_3",   0,1, 3, 0,0, 0,1,   0,0,0,   0,0,0,   0,0,0,   2,2);
        step("fly_1",     0,1, 1, 0,0, 0,0,   1,0,0,   0,0,0,   0,0,0,   2,2);
        step("fly_2",     0,1, 2, 1,0, 0,0,   2,1,0,   1,0,0,   0,0,0,   2,2);
        step("fly_3",     0,1, 3, 0,1, 0,0,   3,0,1,   2,1,0,   1,1,0,   2,2);
        step("mid_rst",   1,1, 4, 0,0, 1,1,   0,0,0,   0,0,0,   0,0,0,   0,0);
        for (int k = 1; k <= 17; k++)
            step("wrap",  0,1, 6, 0,0, 1,0,   0,0,0,   0,0,0,   0,0,0,   4'(k),0);
        step("post_ex",   0,1, 6, 0,0, 0,0,   6,0,0,   0,0,0,   0,0,0,   1,0);
        step("post_mem",  0,0, 0, 0,0, 0,0,   0,0,0,   6,0,0,   0,0,0,   1,0);
        step("post_wb",   0,0, 0, 0,0, 0,0,   0,0,0,   0,0,0,   6,1,0,   1,0);
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
